serial_frame_tx: RTL and testbench

- Moore-style serial transmitter; the producer end of the single-bit serial line that the team's Moore FSM receivers consume on their in_i input.
- Accepts a WIDTH-bit parallel word over a valid/ready handshake.
- Emits the word on one line as a frame: start bit, data bits LSB first, stop bit.
- Each bit is held for BIT_CYCLES clocks; out_o is a registered function of state only.

---
 rtl/serial_frame_tx.sv | 89 ++++++++
 tb/tb_serial_frame_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: Moore serial transmitter sending start bit, WIDTH data bits LSB first and stop bit.
module serial_frame_tx #(
  parameter int WIDTH = 3,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             out_q, out_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             bit_end, last_bit;
  always_comb begin
    bit_end  = cnt_q == CNT_MAX;
    last_bit = idx_q == IDX_MAX;
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_i && ready_q) begin
          shreg_d = data_i;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        idx_d   = last_bit ? idx_q : idx_q + 1'b1;
        state_d = last_bit ? STOP : DATA;
      end
      default: if (bit_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
    // outputs are precomputed from the next state so they come straight out of flops
    out_d   = (state_d == START) || (state_d == DATA && shreg_d[0]);
    ready_d = state_d == IDLE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign ready_o = ready_q;
  assign out_o   = out_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: two instances (BIT_CYCLES 1 and 2) checked each cycle against a frame-position model.
module tb_serial_frame_tx;
  localparam int W = 3;
  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         rdy[2], lo[2], bsy[2], dn[2];
  logic [1:0]   st[2];
  int           n_chk = 0, n_fail = 0;
  int           pos[2] = '{-1, -1};
  logic [W-1:0] w[2];
  logic         dm[2] = '{1'b0, 1'b0};
  logic [31:0]  qo[2], qd[2], qb[2], qr[2];
  logic [1:0]   qs[2][32];

  serial_frame_tx #(.WIDTH(W), .BIT_CYCLES(1)) u0 (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy[0]), .out_o(lo[0]), .busy_o(bsy[0]), .done_o(dn[0]), .state_o(st[0]));
  serial_frame_tx #(.WIDTH(W), .BIT_CYCLES(2)) u1 (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy[1]), .out_o(lo[1]), .busy_o(bsy[1]), .done_o(dn[1]), .state_o(st[1]));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame slot k = pos/bc: slot 0 is the start bit, 1..W are data bits, W+1 is the stop bit.
  function automatic logic [1:0] exp_state(input int i);
    int k;
    if (pos[i] < 0) return 2'd0;
    k = pos[i] / (i + 1);
    return k == 0 ? 2'd1 : (k <= W ? 2'd2 : 2'd3);
  endfunction

  function automatic logic exp_out(input int i);
    int k;
    if (pos[i] < 0) return 1'b0;
    k = pos[i] / (i + 1);
    return k == 0 ? 1'b1 : (k <= W ? w[i][k-1] : 1'b0);
  endfunction

  always @(posedge clk_i) begin
    logic v, r;
    logic [W-1:0] d;
    v = valid_i;
    r = reset_ni;
    d = data_i;
    #1;
    for (int i = 0; i < 2; i++) begin
      dm[i] = 1'b0;
      if (!r) pos[i] = -1;
      else if (pos[i] < 0) begin
        if (v) begin
          pos[i] = 0;
          w[i] = d;
        end
      end else if (pos[i] == (W + 2) * (i + 1) - 1) begin
        pos[i] = -1;
        dm[i] = 1'b1;
      end else pos[i]++;
      chk($sformatf("u%0d state", i), 32'(st[i]), 32'(exp_state(i)));
      chk($sformatf("u%0d out", i), 32'(lo[i]), 32'(exp_out(i)));
      chk($sformatf("u%0d ready", i), 32'(rdy[i]), 32'(pos[i] < 0));
      chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(pos[i] >= 0));
      chk($sformatf("u%0d done", i), 32'(dn[i]), 32'(dm[i]));
    end
  end

  task automatic rec(input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      for (int i = 0; i < 2; i++) begin
        qo[i][k] = lo[i];
        qd[i][k] = dn[i];
        qb[i][k] = bsy[i];
        qr[i][k] = rdy[i];
        qs[i][k] = st[i];
      end
      @(negedge clk_i);
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    data_i = d;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  initial begin
    logic [11:0] sv;
    #1 reset_ni = 1'b0;
    @(negedge clk_i);
    chk("reset out", 32'(lo[0]), 32'd0);
    chk("reset ready", 32'(rdy[0]), 32'd1);
    chk("reset state", 32'(st[0]), 32'd0);
    repeat (4) @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    // single frame, one cycle per bit
    send(3'b101);
    rec(0, 6);
    chk("t1 out seq", qo[0][4:0], 32'b01011);
    chk("t1 done", qd[0][5:0], 32'b100000);
    chk("t1 end state", 32'(qs[0][5]), 32'd0);
    repeat (12) @(negedge clk_i);
    // two cycles per bit
    send(3'b110);
    rec(0, 11);
    chk("t2 out seq", qo[1][9:0], 32'b0011110011);
    chk("t2 busy", qb[1][10:0], 32'h3FF);
    chk("t2 ready", qr[1][10:0], 32'h400);
    chk("t2 done", qd[1][10:0], 32'h400);
    repeat (12) @(negedge clk_i);
    // valid held high: back-to-back frames with a one-cycle gap
    data_i = 3'b011;
    valid_i = 1'b1;
    @(negedge clk_i);
    data_i = 3'b100;
    rec(0, 6);
    valid_i = 1'b0;
    rec(6, 6);
    chk("t3 out seq", qo[0][10:0], 32'b01001000111);
    chk("t3 done", qd[0][11:0], 32'b100000100000);
    repeat (12) @(negedge clk_i);
    // async reset in the middle of the data bits
    send(3'b101);
    @(negedge clk_i);
    chk("t4 in data", 32'(st[0]), 32'd2);
    #1 reset_ni = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t4 u%0d async out", i), 32'(lo[i]), 32'd0);
      chk($sformatf("t4 u%0d async state", i), 32'(st[i]), 32'd0);
      chk($sformatf("t4 u%0d async ready", i), 32'(rdy[i]), 32'd1);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    rec(0, 8);
    chk("t4 u0 quiet", qo[0][7:0], 32'd0);
    chk("t4 u1 quiet", qo[1][7:0], 32'd0);
    chk("t4 u0 idle", qb[0][7:0], 32'd0);
    // valid pulsed while busy is ignored
    send(3'b001);
    rec(0, 1);
    data_i = 3'b111;
    valid_i = 1'b1;
    rec(1, 1);
    valid_i = 1'b0;
    rec(2, 9);
    chk("t5 out seq", qo[0][10:0], 32'b00000000011);
    chk("t5 done", qd[0][10:0], 32'b00000100000);
    chk("t5 busy", qb[0][10:0], 32'b00000011111);
    repeat (12) @(negedge clk_i);
    // data_i churns after acceptance
    send(3'b010);
    for (int k = 0; k < 6; k++) begin
      data_i = W'($urandom);
      rec(k, 1);
    end
    sv = {qs[0][5], qs[0][4], qs[0][3], qs[0][2], qs[0][1], qs[0][0]};
    chk("t6 state seq", 32'(sv), 32'b00_11_10_10_10_01);
    chk("t6 out seq", qo[0][4:0], 32'b00101);
    repeat (12) @(negedge clk_i);
    // randomized traffic with occasional async resets
    for (int c = 0; c < 3000; c++) begin
      valid_i = ($urandom % 4) == 0;
      data_i = W'($urandom);
      if ($urandom % 200 == 0) begin
        #2 reset_ni = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
      end else @(negedge clk_i);
    end
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
